// File: rtl/skein_pkg.sv
// Shared widths, scheduler state encoding and in-flight tag layout for the
// skein512 nonce scheduler.
package skein_pkg;

  localparam int NONCE_W = 32;
  localparam int HASH_W  = 512;
  localparam int DATA_W  = 96;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One in-flight nonce travelling alongside the hash core at the default
  // nonce width.
  typedef struct packed {
    logic               valid;
    logic [NONCE_W-1:0] nonce;
  } tag_t;

endpackage

// File: rtl/skein_tag_pipe.sv
// Delay line of {valid, nonce} tags matched to the skein512 core latency.
// The tag written in cycle t is presented on the outputs in cycle t+LATENCY,
// the same cycle the core presents the hash of that nonce. Flush clears every
// valid bit at the next edge, including the tag being written in that cycle.
module skein_tag_pipe #(
  parameter int LATENCY = 20,
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [NONCE_W-1:0] in_nonce,
  output logic               out_valid,
  output logic [NONCE_W-1:0] out_nonce,
  output logic               any_valid
);

  logic [LATENCY-1:0] valid_q;
  logic [NONCE_W-1:0] nonce_q [LATENCY];

  // Valid bits shift one stage per cycle; flush empties the whole line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Nonce payload shifts unconditionally; only the valid bits carry meaning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        nonce_q[i] <= '0;
      end
    end else begin
      nonce_q[0] <= in_nonce;
      for (int i = 1; i < LATENCY; i++) begin
        nonce_q[i] <= nonce_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_nonce = nonce_q[LATENCY-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/skein_nonce_scheduler.sv
// Sweeps an inclusive nonce range through a pipelined skein512 core, one
// nonce per cycle, and reports the first nonce whose hash slice is at or
// below the job target, or exhaustion of the range.
//
// state | meaning
// IDLE  | no job; waiting for start, results held
// SCAN  | issuing one nonce per cycle to the core
// DRAIN | all nonces issued; waiting for in-flight hashes to emerge
//
// done is asserted in the final cycle of a job, while state is still SCAN or
// DRAIN; found/found_nonce/found_hash update on the edge that ends the job.
module skein_nonce_scheduler
  import skein_pkg::state_e, skein_pkg::IDLE, skein_pkg::SCAN, skein_pkg::DRAIN,
         skein_pkg::HASH_W, skein_pkg::DATA_W;
#(
  parameter int LATENCY = 20,
  parameter int NONCE_W = skein_pkg::NONCE_W,
  parameter int CMP_W   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [HASH_W-1:0]  midstate_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  input  logic [CMP_W-1:0]   target,
  output logic [HASH_W-1:0]  core_midstate,
  output logic [DATA_W-1:0]  core_data,
  output logic [NONCE_W-1:0] core_nonce,
  input  logic [HASH_W-1:0]  core_hash,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [HASH_W-1:0]  found_hash
);

  localparam logic [NONCE_W:0]   CNT_ONE   = 1;
  localparam logic [NONCE_W-1:0] NONCE_ONE = 1;

  state_e             state_q;
  state_e             state_d;

  logic [HASH_W-1:0]  mid_q;
  logic [DATA_W-1:0]  data_q;
  logic [CMP_W-1:0]   target_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W:0]   count_q;
  logic [NONCE_W-1:0] span;

  logic               found_q;
  logic [NONCE_W-1:0] found_nonce_q;
  logic [HASH_W-1:0]  found_hash_q;

  logic               tag_out_valid;
  logic [NONCE_W-1:0] tag_out_nonce;
  logic               tag_any;

  logic               take_start;
  logic               last_issue;
  logic               hit;
  logic               push_valid;
  logic               flush;
  logic               busy_c;
  logic               done_c;

  // Range size minus one; the count register holds this plus one in
  // NONCE_W+1 bits so a wrapped range can cover all 2^NONCE_W nonces.
  assign span       = nonce_last - nonce_first;
  assign take_start = (state_q == IDLE) && start && !abort;
  assign last_issue = (count_q == CNT_ONE);
  assign hit        = (state_q != IDLE) && tag_out_valid &&
                      (core_hash[CMP_W-1:0] <= target_q);

  skein_tag_pipe #(
    .LATENCY (LATENCY),
    .NONCE_W (NONCE_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (push_valid),
    .in_nonce  (nonce_q),
    .out_valid (tag_out_valid),
    .out_nonce (tag_out_nonce),
    .any_valid (tag_any)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: abort beats everything, a hit beats the last issue.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = SCAN;
        end
        SCAN: begin
          if (hit)             state_d = IDLE;
          else if (last_issue) state_d = DRAIN;
        end
        DRAIN: begin
          if (hit || !tag_any) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: tag push, pipe flush, busy and the end-of-job pulse.
  always_comb begin
    push_valid = 1'b0;
    flush      = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      SCAN: begin
        push_valid = 1'b1;
        busy_c     = 1'b1;
        flush      = abort || hit;
        done_c     = !abort && hit;
      end
      DRAIN: begin
        busy_c = 1'b1;
        flush  = abort || hit;
        done_c = !abort && (hit || !tag_any);
      end
      default: begin
        flush = abort;
      end
    endcase
  end

  // Job context and issue counters; the nonce only advances while the FSM
  // stays in SCAN, so core_nonce holds the last value driven to the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_q    <= '0;
      data_q   <= '0;
      target_q <= '0;
      nonce_q  <= '0;
      count_q  <= '0;
    end else if (take_start) begin
      mid_q    <= midstate_in;
      data_q   <= data_in;
      target_q <= target;
      nonce_q  <= nonce_first;
      count_q  <= {1'b0, span} + CNT_ONE;
    end else if (state_q == SCAN) begin
      count_q <= count_q - CNT_ONE;
      if (state_d == SCAN) begin
        nonce_q <= nonce_q + NONCE_ONE;
      end
    end
  end

  // Held result of the most recent job; cleared on start and on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
    end else if (abort) begin
      found_q <= 1'b0;
    end else if (take_start) begin
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
    end else if (hit) begin
      found_q       <= 1'b1;
      found_nonce_q <= tag_out_nonce;
      found_hash_q  <= core_hash;
    end
  end

  assign core_midstate = mid_q;
  assign core_data     = data_q;
  assign core_nonce    = nonce_q;
  assign busy          = busy_c;
  assign done          = done_c;
  assign found         = found_q;
  assign found_nonce   = found_nonce_q;
  assign found_hash    = found_hash_q;

endmodule

// File: tb/tb_skein_nonce_scheduler.sv
// Directed bench for skein_nonce_scheduler with a 4-cycle behavioural core.
module tb_skein_nonce_scheduler;

  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [511:0] midstate_in = '0;
  logic [95:0]  data_in = '0;
  logic [31:0]  nonce_first = '0;
  logic [31:0]  nonce_last = '0;
  logic [63:0]  target = '0;
  logic [511:0] core_midstate;
  logic [95:0]  core_data;
  logic [31:0]  core_nonce;
  logic [511:0] core_hash;
  logic         busy;
  logic         done;
  logic         found;
  logic [31:0]  found_nonce;
  logic [511:0] found_hash;

  always #5 clk = ~clk;

  skein_nonce_scheduler #(.LATENCY(L), .NONCE_W(32), .CMP_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .midstate_in   (midstate_in),
    .data_in       (data_in),
    .nonce_first   (nonce_first),
    .nonce_last    (nonce_last),
    .target        (target),
    .core_midstate (core_midstate),
    .core_data     (core_data),
    .core_nonce    (core_nonce),
    .core_hash     (core_hash),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .found_nonce   (found_nonce),
    .found_hash    (found_hash)
  );

  function automatic logic [511:0] hash_of(input logic [31:0] n);
    return {{14{n}}, ({32'h0, n} ^ 64'hFFFF)};
  endfunction

  // Behavioural core: hash of the nonce seen L cycles earlier.
  logic [31:0] hp [L];
  always @(posedge clk) begin
    hp[0] <= core_nonce;
    for (int i = 1; i < L; i++) hp[i] <= hp[i-1];
  end
  assign core_hash = hash_of(hp[L-1]);

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  cn;
    logic [31:0]  fn;
    logic [511:0] fh;
    logic [511:0] mid;
    logic [95:0]  dat;
  } exp_t;

  longint       cyc = 0;
  int           tests = 0;
  int           fails = 0;
  int           done_count = 0;
  longint       last_done_cyc = -1;

  // Job model: cycle of start, last busy cycle, done cycle, last issue cycle.
  bit           m_valid = 0;
  longint       m_s, m_end, m_done, m_issue_end;
  logic [31:0]  m_first, m_hit_nonce;
  bit           m_hit;
  logic [511:0] m_mid;
  logic [95:0]  m_data;
  exp_t         prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t exp_at(input longint c);
    exp_t   e;
    longint k;
    e = prev;
    e.busy = 1'b0;
    e.done = 1'b0;
    if (!m_valid || c <= m_s) return e;
    e.busy  = (c <= m_end);
    e.done  = (m_done >= 0) && (c == m_done);
    e.found = m_hit && (m_done >= 0) && (c > m_done);
    e.fn    = e.found ? m_hit_nonce : 32'h0;
    e.fh    = e.found ? hash_of(m_hit_nonce) : 512'h0;
    k       = ((c < m_issue_end) ? c : m_issue_end) - m_s - 1;
    e.cn    = m_first + k[31:0];
    e.mid   = m_mid;
    e.dat   = m_data;
    return e;
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) e = '0;
    else        e = exp_at(cyc);
    check("busy",          {511'h0, busy},  {511'h0, e.busy});
    check("done",          {511'h0, done},  {511'h0, e.done});
    check("found",         {511'h0, found}, {511'h0, e.found});
    check("core_nonce",    {480'h0, core_nonce},  {480'h0, e.cn});
    check("found_nonce",   {480'h0, found_nonce}, {480'h0, e.fn});
    check("found_hash",    found_hash, e.fh);
    check("core_midstate", core_midstate, e.mid);
    check("core_data",     {416'h0, core_data}, {416'h0, e.dat});
    if (done) begin
      done_count++;
      last_done_cyc = cyc;
    end
  end

  task automatic start_job(input logic [31:0] f, input logic [31:0] l, input logic [63:0] t,
                           input logic [511:0] mid, input logic [95:0] d);
    longint       n;
    longint       h;
    bit           hit;
    logic [511:0] hv;
    prev = exp_at(cyc);
    n = longint'({1'b0, l - f}) + 1;
    hit = 0;
    h = 0;
    for (longint i = 0; i < n && i < 65536 && !hit; i++) begin
      hv = hash_of(f + i[31:0]);
      if (hv[63:0] <= t) begin
        hit = 1;
        h = i;
      end
    end
    m_s = cyc;
    m_first = f;
    m_mid = mid;
    m_data = d;
    m_hit = hit;
    m_hit_nonce = f + h[31:0];
    if (hit) begin
      m_done = cyc + 1 + h + L;
      m_issue_end = (cyc + n < m_done) ? cyc + n : m_done;
    end else begin
      m_done = cyc + n + L + 1;
      m_issue_end = cyc + n;
    end
    m_end = m_done;
    m_valid = 1;
    nonce_first = f;
    nonce_last = l;
    target = t;
    midstate_in = mid;
    data_in = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic abort_job();
    m_end = cyc;
    m_done = -1;
    m_hit = 0;
    if (m_issue_end > cyc) m_issue_end = cyc;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic wait_done(input longint s, input longint exp_off, input string nm);
    int dc0;
    dc0 = done_count;
    for (int k = 0; k < 200 && done_count == dc0; k++) @(negedge clk);
    if (done_count == dc0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no done within 200 cycles", nm);
    end else begin
      check({nm, " latency"}, 512'(last_done_cyc - s), 512'(exp_off));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    longint      s;
    int          dc;
    logic [31:0] seq [4];
    seq[0] = 32'hFFFF_FFFE;
    seq[1] = 32'hFFFF_FFFF;
    seq[2] = 32'h0000_0000;
    seq[3] = 32'h0000_0001;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Exhaustion without hit: 4 nonces, done 9 cycles after start.
    s = cyc;
    start_job(32'h10, 32'h13, 64'h0, {16{32'hA5A5_0001}}, 96'h1111);
    wait_done(s, 9, "job1");
    check("job1 found", {511'h0, found}, 512'h0);
    check("job1 busy",  {511'h0, busy},  512'h0);

    // First qualifying nonce is 0x15; done when its hash emerges.
    s = cyc;
    start_job(32'h10, 32'h20, 64'hFFEA, {16{32'h5A5A_0002}}, 96'h2222);
    wait_done(s, 10, "job2");
    check("job2 found",       {511'h0, found}, 512'h1);
    check("job2 found_nonce", {480'h0, found_nonce}, 512'h15);
    check("job2 hash slice",  {448'h0, found_hash[63:0]}, 512'hFFEA);

    // Wrapping range issued right away; stale tags must not produce hits.
    s = cyc;
    start_job(32'hFFFF_FFFE, 32'h0000_0001, 64'hFFFD, {16{32'h0BAD_F00D}}, 96'h3333);
    for (int i = 0; i < 4; i++) begin
      check("job3 wrap seq", {480'h0, core_nonce}, {480'h0, seq[i]});
      @(posedge clk); #1;
    end
    wait_done(s, 9, "job3");
    check("job3 found", {511'h0, found}, 512'h0);

    // Single-nonce range.
    s = cyc;
    start_job(32'h5, 32'h5, 64'h0, {16{32'h1234_5678}}, 96'h4444);
    wait_done(s, 6, "job4");
    check("job4 core_nonce", {480'h0, core_nonce}, 512'h5);

    // Abort two cycles into SCAN: no done, then a fresh job hits.
    s = cyc;
    dc = done_count;
    start_job(32'h0, 32'hFF, 64'h0, {16{32'hCAFE_0005}}, 96'h5555);
    @(posedge clk); #1;
    abort_job();
    repeat (6) @(posedge clk);
    #1;
    check("abort no done", 512'(done_count), 512'(dc));
    check("abort busy",    {511'h0, busy}, 512'h0);
    s = cyc;
    start_job(32'h15, 32'h15, 64'hFFEA, {16{32'hBEEF_0006}}, 96'h6666);
    wait_done(s, 5, "job6");
    check("job6 found",       {511'h0, found}, 512'h1);
    check("job6 found_nonce", {480'h0, found_nonce}, 512'h15);

    // Long job: ignored start during SCAN, then reset in the middle of DRAIN.
    s = cyc;
    start_job(32'h100, 32'h10F, 64'h0, {16{32'hD00D_0007}}, 96'h7777);
    @(posedge clk); #1;
    @(posedge clk); #1;
    nonce_first = 32'h999;
    nonce_last = 32'h999;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("job7 still busy", {511'h0, busy}, 512'h1);
    rst_n = 1'b0;
    m_valid = 0;
    prev = '0;
    #1;
    check("reset busy",     {511'h0, busy}, 512'h0);
    check("reset nonce",    {480'h0, core_nonce}, 512'h0);
    check("reset midstate", core_midstate, 512'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    start_job(32'h20, 32'h22, 64'h0, {16{32'hFACE_0008}}, 96'h8888);
    wait_done(s, 8, "job8");
    check("job8 found", {511'h0, found}, 512'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
